// File: rtl/bf16_mult_pipe.sv
// bf16_mult_pipe: LANES parallel bf16 x bf16 -> fp32 multipliers in a
// 3-stage valid/ready pipeline (S1 unpack/classify, S2 significand multiply
// plus exponent sum, S3 normalise/special select). Products are exact, so no
// rounding stage exists. Subnormal inputs are treated as signed zero.
// Optional feature: define BF16_MULT_PIPE_EXC_FLAGS_EN to add out_flags,
// per lane {invalid, overflow, underflow}, travelling with the result.
module bf16_mult_pipe #(
  parameter int LANES = 4,
  parameter int TAG_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [16*LANES-1:0]   in_a,
  input  logic [16*LANES-1:0]   in_b,
  input  logic [TAG_W-1:0]      in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [32*LANES-1:0]   out_o,
`ifdef BF16_MULT_PIPE_EXC_FLAGS_EN
  output logic [TAG_W-1:0]      out_tag,
  output logic [3*LANES-1:0]    out_flags
`else
  output logic [TAG_W-1:0]      out_tag
`endif
);

  localparam logic [31:0] CANON_NAN = 32'h7FFF_FFFF;

  logic vld_p0_q, vld_p0_d, vld_p1_q, vld_p1_d, vld_p2_q, vld_p2_d;
  logic adv_p0, adv_p1, adv_p2;

  logic [TAG_W-1:0]       tag_p0_q, tag_p0_d;
  logic [LANES-1:0]       sgn_p0_q, sgn_p0_d, nan_p0_q, nan_p0_d;
  logic [LANES-1:0]       inf_p0_q, inf_p0_d, zro_p0_q, zro_p0_d;
  logic [LANES-1:0][7:0]  ea_p0_q, ea_p0_d, eb_p0_q, eb_p0_d;
  logic [LANES-1:0][6:0]  ma_p0_q, ma_p0_d, mb_p0_q, mb_p0_d;

  logic [TAG_W-1:0]       tag_p1_q, tag_p1_d;
  logic [LANES-1:0]       sgn_p1_q, sgn_p1_d, nan_p1_q, nan_p1_d;
  logic [LANES-1:0]       inf_p1_q, inf_p1_d, zro_p1_q, zro_p1_d;
  logic [LANES-1:0][15:0] prod_p1_q, prod_p1_d;
  logic signed [9:0]      esum_p1_q [LANES];
  logic signed [9:0]      esum_p1_d [LANES];

  logic [TAG_W-1:0]       tag_p2_q, tag_p2_d;
  logic [LANES-1:0][31:0] res_p2_q, res_p2_d;

`ifdef BF16_MULT_PIPE_EXC_FLAGS_EN
  logic [LANES-1:0]       sub_p0_q, sub_p0_d, sub_p1_q, sub_p1_d;
  logic [LANES-1:0][2:0]  flg_p2_q, flg_p2_d;
`endif

  function automatic logic is_zero(input logic [7:0] e);
    return e == 8'd0;
  endfunction

  function automatic logic is_inf(input logic [7:0] e, input logic [6:0] m);
    return (e == 8'hFF) && (m == 7'd0);
  endfunction

  function automatic logic is_nan(input logic [7:0] e, input logic [6:0] m);
    return (e == 8'hFF) && (m != 7'd0);
  endfunction

  // Exponent after the optional one-place normalising shift.
  function automatic logic signed [9:0] norm_exp(input logic signed [9:0] esum,
                                                 input logic msb);
    return esum + (msb ? 10'sd1 : 10'sd0);
  endfunction

  // The product carries 14 fraction bits; drop the hidden one and left-align.
  function automatic logic [22:0] norm_frac(input logic [15:0] prod);
    return prod[15] ? {prod[14:0], 8'd0} : {prod[13:0], 9'd0};
  endfunction

  // Saturate to signed inf on overflow, flush to signed zero on underflow.
  function automatic logic [31:0] sat_pack(input logic sgn, input logic signed [9:0] e,
                                           input logic [22:0] frac);
    if (e >= 10'sd255) return {sgn, 8'hFF, 23'd0};
    if (e <= 10'sd0)   return {sgn, 31'd0};
    return {sgn, e[7:0], frac};
  endfunction

  // Handshake chain: a stage loads when it is empty or its successor moves on.
  always_comb begin
    adv_p2   = out_ready || !vld_p2_q;
    adv_p1   = !vld_p1_q || adv_p2;
    adv_p0   = !vld_p0_q || adv_p1;
    vld_p0_d = adv_p0 ? in_valid : vld_p0_q;
    vld_p1_d = adv_p1 ? vld_p0_q : vld_p1_q;
    vld_p2_d = adv_p2 ? vld_p1_q : vld_p2_q;
  end

  assign in_ready = adv_p0;

  // Stage valid bits; reset empties the pipe and discards in-flight sets.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p0_q <= 1'b0;
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
    end else begin
      vld_p0_q <= vld_p0_d;
      vld_p1_q <= vld_p1_d;
      vld_p2_q <= vld_p2_d;
    end
  end

  // S1 (p0): unpack fields and classify zero/inf/nan per lane.
  always_comb begin
    tag_p0_d = tag_p0_q;
    sgn_p0_d = sgn_p0_q;
    nan_p0_d = nan_p0_q;
    inf_p0_d = inf_p0_q;
    zro_p0_d = zro_p0_q;
    ea_p0_d  = ea_p0_q;
    eb_p0_d  = eb_p0_q;
    ma_p0_d  = ma_p0_q;
    mb_p0_d  = mb_p0_q;
`ifdef BF16_MULT_PIPE_EXC_FLAGS_EN
    sub_p0_d = sub_p0_q;
`endif
    if (adv_p0 && in_valid) begin
      tag_p0_d = in_tag;
      for (int i = 0; i < LANES; i++) begin
        ea_p0_d[i]  = in_a[16*i+7 +: 8];
        eb_p0_d[i]  = in_b[16*i+7 +: 8];
        ma_p0_d[i]  = in_a[16*i +: 7];
        mb_p0_d[i]  = in_b[16*i +: 7];
        sgn_p0_d[i] = in_a[16*i+15] ^ in_b[16*i+15];
        zro_p0_d[i] = is_zero(ea_p0_d[i]) || is_zero(eb_p0_d[i]);
        inf_p0_d[i] = is_inf(ea_p0_d[i], ma_p0_d[i]) || is_inf(eb_p0_d[i], mb_p0_d[i]);
        nan_p0_d[i] = is_nan(ea_p0_d[i], ma_p0_d[i]) || is_nan(eb_p0_d[i], mb_p0_d[i]) ||
                      (is_inf(ea_p0_d[i], ma_p0_d[i]) && is_zero(eb_p0_d[i])) ||
                      (is_zero(ea_p0_d[i]) && is_inf(eb_p0_d[i], mb_p0_d[i]));
`ifdef BF16_MULT_PIPE_EXC_FLAGS_EN
        sub_p0_d[i] = (is_zero(ea_p0_d[i]) && (ma_p0_d[i] != 7'd0)) ||
                      (is_zero(eb_p0_d[i]) && (mb_p0_d[i] != 7'd0));
`endif
      end
    end
  end

  // S2 (p1): exact 8x8 significand product and biased exponent sum.
  always_comb begin
    tag_p1_d  = tag_p1_q;
    sgn_p1_d  = sgn_p1_q;
    nan_p1_d  = nan_p1_q;
    inf_p1_d  = inf_p1_q;
    zro_p1_d  = zro_p1_q;
    prod_p1_d = prod_p1_q;
    esum_p1_d = esum_p1_q;
`ifdef BF16_MULT_PIPE_EXC_FLAGS_EN
    sub_p1_d  = sub_p1_q;
`endif
    if (adv_p1 && vld_p0_q) begin
      tag_p1_d = tag_p0_q;
      sgn_p1_d = sgn_p0_q;
      nan_p1_d = nan_p0_q;
      inf_p1_d = inf_p0_q;
      zro_p1_d = zro_p0_q;
`ifdef BF16_MULT_PIPE_EXC_FLAGS_EN
      sub_p1_d = sub_p0_q;
`endif
      for (int i = 0; i < LANES; i++) begin
        prod_p1_d[i] = 16'({1'b1, ma_p0_q[i]}) * 16'({1'b1, mb_p0_q[i]});
        esum_p1_d[i] = signed'({2'b00, ea_p0_q[i]}) + signed'({2'b00, eb_p0_q[i]}) - 10'sd127;
      end
    end
  end

  // S3 (p2): normalise and select special results; holds while stalled.
  always_comb begin : s3_comb
    logic signed [9:0] exp_n;
    exp_n    = '0;
    tag_p2_d = tag_p2_q;
    res_p2_d = res_p2_q;
`ifdef BF16_MULT_PIPE_EXC_FLAGS_EN
    flg_p2_d = flg_p2_q;
`endif
    if (adv_p2 && vld_p1_q) begin
      tag_p2_d = tag_p1_q;
      for (int i = 0; i < LANES; i++) begin
        exp_n = norm_exp(esum_p1_q[i], prod_p1_q[i][15]);
        if (nan_p1_q[i])      res_p2_d[i] = CANON_NAN;
        else if (inf_p1_q[i]) res_p2_d[i] = {sgn_p1_q[i], 8'hFF, 23'd0};
        else if (zro_p1_q[i]) res_p2_d[i] = {sgn_p1_q[i], 31'd0};
        else res_p2_d[i] = sat_pack(sgn_p1_q[i], exp_n, norm_frac(prod_p1_q[i]));
`ifdef BF16_MULT_PIPE_EXC_FLAGS_EN
        if (nan_p1_q[i])      flg_p2_d[i] = 3'b100;
        else if (inf_p1_q[i]) flg_p2_d[i] = 3'b000;
        else if (zro_p1_q[i]) flg_p2_d[i] = {2'b00, sub_p1_q[i]};
        else flg_p2_d[i] = {1'b0, exp_n >= 10'sd255, exp_n <= 10'sd0};
`endif
      end
    end
  end

  // Datapath registers carry no reset; the valid bits qualify them.
  always_ff @(posedge clk) begin
    tag_p0_q  <= tag_p0_d;
    sgn_p0_q  <= sgn_p0_d;
    nan_p0_q  <= nan_p0_d;
    inf_p0_q  <= inf_p0_d;
    zro_p0_q  <= zro_p0_d;
    ea_p0_q   <= ea_p0_d;
    eb_p0_q   <= eb_p0_d;
    ma_p0_q   <= ma_p0_d;
    mb_p0_q   <= mb_p0_d;
    tag_p1_q  <= tag_p1_d;
    sgn_p1_q  <= sgn_p1_d;
    nan_p1_q  <= nan_p1_d;
    inf_p1_q  <= inf_p1_d;
    zro_p1_q  <= zro_p1_d;
    prod_p1_q <= prod_p1_d;
    esum_p1_q <= esum_p1_d;
    tag_p2_q  <= tag_p2_d;
    res_p2_q  <= res_p2_d;
`ifdef BF16_MULT_PIPE_EXC_FLAGS_EN
    sub_p0_q  <= sub_p0_d;
    sub_p1_q  <= sub_p1_d;
    flg_p2_q  <= flg_p2_d;
`endif
  end

  // Outputs read as zero whenever no result is presented (including reset).
  assign out_valid = vld_p2_q;
  assign out_o     = vld_p2_q ? res_p2_q : '0;
  assign out_tag   = vld_p2_q ? tag_p2_q : '0;
`ifdef BF16_MULT_PIPE_EXC_FLAGS_EN
  assign out_flags = vld_p2_q ? flg_p2_q : '0;
`endif

endmodule

// File: tb/tb_bf16_mult_pipe.sv
// Testbench for bf16_mult_pipe: scoreboard against a value-level bf16 product
// model, plus hand-computed vectors for latency, specials, stalls and reset.
module tb_bf16_mult_pipe;
  localparam int LANES = 4;
  localparam int TAG_W = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [63:0]   in_a = '0;
  logic [63:0]   in_b = '0;
  logic [3:0]    in_tag = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [127:0]  out_o;
  logic [3:0]    out_tag;
`ifdef BF16_MULT_PIPE_EXC_FLAGS_EN
  logic [11:0]   out_flags;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int n_acc   = 0;
  int n_xfer  = 0;

  typedef struct {
    logic [127:0] res;
    logic [11:0]  flg;
    logic [3:0]   tag;
  } exp_t;
  exp_t sbq[$];

  logic [15:0] vals [16];
  logic [63:0] st_a [8];
  logic [63:0] st_b [8];

  always #5 clk = ~clk;

  bf16_mult_pipe #(.LANES(LANES), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_o(out_o),
`ifdef BF16_MULT_PIPE_EXC_FLAGS_EN
    .out_tag(out_tag), .out_flags(out_flags)
`else
    .out_tag(out_tag)
`endif
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Value-level model: {flags[2:0], fp32}; flags = {invalid, overflow, underflow}.
  function automatic logic [34:0] model_lane(input logic [15:0] a, input logic [15:0] b);
    int ea, eb, m, p, e;
    logic s, za, zb, ia, ib, na, nb, sub;
    logic [22:0] frac;
    ea = int'(a[14:7]);
    eb = int'(b[14:7]);
    s  = a[15] ^ b[15];
    za = (ea == 0);
    zb = (eb == 0);
    ia = (ea == 255) && (a[6:0] == 7'd0);
    ib = (eb == 255) && (b[6:0] == 7'd0);
    na = (ea == 255) && (a[6:0] != 7'd0);
    nb = (eb == 255) && (b[6:0] != 7'd0);
    sub = (za && a[6:0] != 7'd0) || (zb && b[6:0] != 7'd0);
    if (na || nb || (ia && zb) || (za && ib)) return {3'b100, 32'h7FFF_FFFF};
    if (ia || ib) return {3'b000, s, 8'hFF, 23'h0};
    if (za || zb) return {2'b00, sub, s, 31'h0};
    // value = m * 2^(ea-134) * 2^(eb-134); leading one of m at bit p
    m = (128 + int'(a[6:0])) * (128 + int'(b[6:0]));
    p = 0;
    for (int k = 0; k < 17; k++) if (m >= (1 << k)) p = k;
    e = ea + eb - 141 + p;
    if (e >= 255) return {3'b010, s, 8'hFF, 23'h0};
    if (e <= 0)   return {3'b001, s, 31'h0};
    frac = 23'(m << (23 - p));
    return {3'b000, s, 8'(e), frac};
  endfunction

  function automatic exp_t model_set(input logic [63:0] a, input logic [63:0] b,
                                     input logic [3:0] tag);
    exp_t x;
    logic [34:0] r;
    x.tag = tag;
    x.res = '0;
    x.flg = '0;
    for (int i = 0; i < LANES; i++) begin
      r = model_lane(a[16*i +: 16], b[16*i +: 16]);
      x.res[32*i +: 32] = r[31:0];
      x.flg[3*i +: 3]   = r[34:32];
    end
    return x;
  endfunction

  // Scoreboard: record accepted sets, check every presented result.
  logic         stalled = 1'b0;
  logic [127:0] held_o;
  logic [3:0]   held_t;
  always @(negedge clk) begin
    if (rst) begin
      sbq.delete();
      stalled = 1'b0;
    end else begin
      if (in_valid && in_ready) begin
        sbq.push_back(model_set(in_a, in_b, in_tag));
        n_acc++;
      end
      if (out_valid) begin
        if (stalled) begin
          chk("hold_out_o", out_o, held_o);
          chk("hold_out_tag", out_tag, held_t);
        end
        if (sbq.size() == 0) begin
          chk("unexpected_out_valid", out_valid, 1'b0);
        end else begin
          chk("sb_out_o", out_o, sbq[0].res);
          chk("sb_out_tag", out_tag, sbq[0].tag);
`ifdef BF16_MULT_PIPE_EXC_FLAGS_EN
          chk("sb_out_flags", out_flags, sbq[0].flg);
`endif
          if (out_ready) begin
            void'(sbq.pop_front());
            n_xfer++;
          end
        end
        stalled = !out_ready;
        held_o  = out_o;
        held_t  = out_tag;
      end else begin
        stalled = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [63:0] a, input logic [63:0] b, input logic [3:0] t);
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    in_tag = t;
  endtask

  task automatic send_one(input logic [63:0] a, input logic [63:0] b, input logic [3:0] t);
    int k;
    drive(a, b, t);
    for (k = 0; k < 50; k++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    if (k == 50) chk("send_timeout_in_ready", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input string name);
    int k;
    for (k = 0; k < 20; k++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    if (k == 20) chk(name, out_valid, 1'b1);
  endtask

  task automatic drain();
    int k;
    for (k = 0; k < 60; k++) begin
      @(negedge clk);
      if (sbq.size() == 0 && !out_valid) break;
    end
    chk("drain_empty", sbq.size(), 0);
    tick();
  endtask

  // Lane0 1.5 x 2 with out_ready high: out_valid exactly 3 cycles later.
  task automatic lat_test(input string name);
    drive({16'h3F80, 16'h3F80, 16'h3F80, 16'h3FC0}, {16'h3F80, 16'h3F80, 16'h3F80, 16'h4000}, 4'h5);
    @(negedge clk);
    chk({name, "_in_ready"}, in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    chk({name, "_valid_c1"}, out_valid, 1'b0);
    @(negedge clk);
    chk({name, "_valid_c2"}, out_valid, 1'b0);
    @(negedge clk);
    chk({name, "_valid_c3"}, out_valid, 1'b1);
    chk({name, "_lane0"}, out_o[31:0], 32'h4040_0000);
    chk({name, "_tag"}, out_tag, 4'h5);
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [34:0] r;
    int base, cnt, idx, ph;

    vals = '{16'h3F80, 16'h4000, 16'h3FC0, 16'hC040, 16'h7F80, 16'hFF80, 16'h0000, 16'h8000,
             16'h7FC0, 16'h0001, 16'h0080, 16'h7F00, 16'h4120, 16'hBE00, 16'h42C8, 16'h3E80};
    for (int k = 0; k < 8; k++)
      for (int i = 0; i < LANES; i++) begin
        st_a[k][16*i +: 16] = vals[(k*4 + i) % 16];
        st_b[k][16*i +: 16] = vals[(k*3 + i*5 + 1) % 16];
      end

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_o", out_o, 128'h0);
    chk("rst_out_tag", out_tag, 4'h0);
    tick();
    rst = 1'b0;
    out_ready = 1'b1;

    // hand-computed pins for the model
    r = model_lane(16'h3FC0, 16'h4000); chk("model_1p5x2", r, {3'b000, 32'h4040_0000});
    r = model_lane(16'h3FC0, 16'h3FC0); chk("model_1p5x1p5", r, {3'b000, 32'h4010_0000});
    r = model_lane(16'hC040, 16'h4120); chk("model_m3x10", r, {3'b000, 32'hC1F0_0000});
    r = model_lane(16'h7F80, 16'h0000); chk("model_infx0", r, {3'b100, 32'h7FFF_FFFF});
    r = model_lane(16'hFF80, 16'h3F80); chk("model_ninfx1", r, {3'b000, 32'hFF80_0000});
    r = model_lane(16'h8000, 16'h4000); chk("model_nzerox2", r, {3'b000, 32'h8000_0000});
    r = model_lane(16'h7FC1, 16'h3F80); chk("model_nan", r, {3'b100, 32'h7FFF_FFFF});
    r = model_lane(16'h7F00, 16'h7F00); chk("model_ovf", r, {3'b010, 32'h7F80_0000});
    r = model_lane(16'h0080, 16'h0080); chk("model_unf", r, {3'b001, 32'h0000_0000});
    r = model_lane(16'h0001, 16'h3F80); chk("model_subnormal", r, {3'b001, 32'h0000_0000});

    lat_test("lat");

    // special values, one per lane
    send_one({16'h7FC1, 16'h8000, 16'hFF80, 16'h7F80}, {16'h3F80, 16'h4000, 16'h3F80, 16'h0000}, 4'h2);
    wait_out("special_timeout");
    chk("special_out_o", out_o, 128'h7FFFFFFF_80000000_FF800000_7FFFFFFF);
`ifdef BF16_MULT_PIPE_EXC_FLAGS_EN
    chk("special_flags", out_flags, 12'h804);
`endif
    tick();

    // exponent overflow / underflow
    send_one({16'h3F80, 16'h3F80, 16'h0080, 16'h7F00}, {16'h3F80, 16'h3F80, 16'h0080, 16'h7F00}, 4'h3);
    wait_out("range_timeout");
    chk("range_out_o", out_o, 128'h3F800000_3F800000_00000000_7F800000);
`ifdef BF16_MULT_PIPE_EXC_FLAGS_EN
    chk("range_flags", out_flags, 12'h00A);
`endif
    tick();
    drain();

    // stream 8 sets while out_ready toggles 1,0,0,1
    base = n_xfer;
    idx = 0;
    ph = 0;
    for (int c = 0; c < 200 && !(idx == 8 && sbq.size() == 0); c++) begin
      tick();
      out_ready = (ph % 4 == 0) || (ph % 4 == 3);
      ph++;
      if (idx < 8) drive(st_a[idx], st_b[idx], 4'(idx));
      else in_valid = 1'b0;
      @(negedge clk);
      if (in_valid && in_ready) idx++;
    end
    tick();
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("stream_accepted", idx, 8);
    chk("stream_results", n_xfer - base, 8);
    drain();

    // back-pressure fill: 3 accepted, 4th refused until out_ready rises
    out_ready = 1'b0;
    base = n_acc;
    for (int k = 0; k < 4; k++) begin
      tick();
      drive(st_a[k], st_b[k], 4'(8 + k));
      @(negedge clk);
    end
    chk("fill_accepted", n_acc - base, 3);
    chk("fill_in_ready_low", in_ready, 1'b0);
    tick();
    out_ready = 1'b1;
    #1;
    chk("fill_in_ready_rise", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    chk("fill_total_accepted", n_acc - base, 4);
    drain();

    // reset with 3 sets in flight
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      drive(st_a[k+4], st_b[k+4], 4'(12 + k));
    end
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    chk("inflight_out_valid", out_valid, 1'b1);
    tick();
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_out_o", out_o, 128'h0);
    chk("midrst_out_tag", out_tag, 4'h0);
    chk("midrst_in_ready", in_ready, 1'b1);
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    cnt = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (out_valid) cnt++;
    end
    chk("no_stale_results", cnt, 0);
    tick();
    lat_test("post_rst");
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bf16_mult_pipe.md
BF16_MULT_PIPE -- requirements
Module: bf16_mult_pipe

Interface
REQ-001 The block SHALL have parameter LANES, default 4, meaning the number of independent bf16 x bf16 -> fp32 multiplier lanes (legal range 1..16).
REQ-002 The block SHALL have parameter TAG_W, default 4, meaning the width of the sideband tag carried alongside each operand set (legal range 1..16).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The block SHALL have port in_valid, input, 1 bit: an operand set is presented.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block accepts the operand set this cycle.
REQ-007 The block SHALL have port in_a, input, 16*LANES bits: bf16 operand A; lane i occupies bits [16i+15:16i].
REQ-008 The block SHALL have port in_b, input, 16*LANES bits: bf16 operand B, packed as in_a.
REQ-009 The block SHALL have port in_tag, input, TAG_W bits: sideband tag, returned unmodified with the result.
REQ-010 The block SHALL have port out_valid, output, 1 bit: a result is presented.
REQ-011 The block SHALL have port out_ready, input, 1 bit: the downstream accepts the result.
REQ-012 The block SHALL have port out_o, output, 32*LANES bits: fp32 products; lane i occupies bits [32i+31:32i].
REQ-013 The block SHALL have port out_tag, output, TAG_W bits: the tag of the presented result.

Function
REQ-014 Input transfer SHALL occur when in_valid && in_ready; output transfer SHALL occur when out_valid && out_ready.
REQ-015 Pipeline SHALL have 3 stages: S1 unpack/classify, S2 8x8 significand multiply plus exponent sum, S3 normalise/special select; each stage has one valid bit.
REQ-016 Stage k SHALL advance when it is empty or stage k+1 advances; S3 advances when out_ready or !out_valid; bubbles collapse.
REQ-017 in_ready SHALL equal !S1_valid || S1 advances; it SHALL be combinationally independent of in_valid.
REQ-018 Unstalled latency SHALL be 3 cycles from input transfer to out_valid; throughput 1 set/cycle with out_ready held high.
REQ-019 While out_valid && !out_ready, out_o and out_tag SHALL hold stable.
REQ-020 Subnormal inputs (exp==0, mant!=0) SHALL be treated as signed zero.
REQ-021 Either operand NaN, or inf x zero, SHALL yield canonical NaN 0x7FFFFFFF.
REQ-022 Otherwise zero x any finite value SHALL yield a zero whose sign is sign_a^sign_b, and inf x nonzero SHALL yield an inf whose sign is sign_a^sign_b.
REQ-023 Normal path: the product of significands {1,ma} x {1,mb} SHALL be exact in 16 bits; if bit15 is set, shift right 1 and add 1 to the exponent.
REQ-024 Biased result exponent SHALL be ea+eb-127 (+1 if normalised), computed in 10-bit signed arithmetic, with no rounding required.
REQ-025 A result exponent of 255 or more SHALL saturate to signed inf; a result exponent of 0 or less SHALL flush to signed zero.
REQ-026 Lanes SHALL be fully independent; a special case in one lane SHALL not affect any other lane.

Reset
REQ-027 While rst is high, all stage valid bits SHALL be 0, out_valid SHALL be 0, out_o SHALL be 0, out_tag SHALL be 0, and in_ready SHALL be 1.
REQ-028 Reset asserted mid-operation SHALL discard all in-flight sets; no result for them SHALL appear after rst deasserts.

Configuration
REQ-029 With macro BF16_MULT_PIPE_EXC_FLAGS_EN defined, the block SHALL add output out_flags (3*LANES bits); lane i holds {invalid, overflow, underflow}, aligned with and held alongside out_o.
REQ-030 invalid SHALL be set for the NaN cases of REQ-021, overflow for inf saturation, and underflow for flush-to-zero from exponent underflow or a subnormal input.
REQ-031 With BF16_MULT_PIPE_EXC_FLAGS_EN undefined, out_flags and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-032 Lane0 inputs 0x3FC0 x 0x4000 (1.5 x 2), out_ready=1 -> out_o lane0 = 0x40400000 exactly 3 cycles after the input transfer.
REQ-033 Lane0 0x7F80 x 0x0000 -> 0x7FFFFFFF; lane1 0xFF80 x 0x3F80 -> 0xFF800000; lane2 0x8000 x 0x4000 -> 0x80000000; lane3 0x7FC1 x 0x3F80 -> 0x7FFFFFFF; the flags build reports invalid on lanes 0 and 3 only.
REQ-034 Lane0 0x7F00 x 0x7F00 -> 0x7F800000 (overflow flag set); lane1 0x0080 x 0x0080 -> 0x00000000 (underflow flag set).
REQ-035 Stream 8 sets with tags 0..7 while out_ready toggles 1,0,0,1 repeatedly -> exactly 8 results in tag order, with no loss or duplication and out_o stable while stalled.
REQ-036 With out_ready=0, issue 4 sets -> 3 are accepted and in_ready goes low; raise out_ready -> the pipeline drains in order and in_ready rises the same cycle.
REQ-037 Assert rst for 1 cycle with 3 sets in flight -> out_valid=0 immediately; after release, no stale result appears and a new set yields its correct result at latency 3.
